demux_route_sched: RTL and testbench



---
 rtl/demux_pkg.sv | 20 ++
 rtl/demux_route_sched_sat_counter.sv | 24 ++
 rtl/demux_route_sched.sv | 109 ++++++++++
 tb/tb_demux_route_sched.sv | 344 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/demux_pkg.sv
// Shared types for the 1x4 demux route scheduler.
// Channel select type, FSM states and channel count.
package demux_pkg;

  localparam int NUM_CH = 4;

  typedef logic [1:0] ch_sel_t;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    DRIVE,
    RELEASE
  } sched_state_t;

  function automatic logic [NUM_CH-1:0] ch_onehot(input ch_sel_t c);
    return NUM_CH'(1) << c;
  endfunction

endpackage

// File: rtl/demux_route_sched_sat_counter.sv
// Saturating up-counter with synchronous clear.
// Clear wins over increment; the count never wraps.
module sat_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] value
);

  // count up on inc, stick at all-ones, clear has priority
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value <= '0;
    end else if (clr) begin
      value <= '0;
    end else if (inc && (value != '1)) begin
      value <= value + CNT_W'(1);
    end
  end

endmodule

// File: rtl/demux_route_sched.sv
// Glitch-safe scheduler feeding the 1x4 latching demux.
// Select settles, data is held, then select outlives data.
module demux_route_sched
  import demux_pkg::*;
#(
  parameter int HOLD_CYCLES = 2,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_data,
  input  logic [1:0]       in_dest,
  output logic             i,
  output logic             s1,
  output logic             s0,
  output logic             drv_en,
  output logic             busy,
  input  logic             cnt_clr,
  input  logic [1:0]       cnt_sel,
  output logic [CNT_W-1:0] cnt_out
);

  localparam int HW = 8;

  if (HOLD_CYCLES < 1 || HOLD_CYCLES > 255) begin : g_bad_hold
    $error("HOLD_CYCLES must be within 1..255");
  end

  sched_state_t      state;
  logic              cap_data;
  ch_sel_t           cap_dest;
  logic [HW-1:0]     hold_cnt;
  logic              drive_done;
  logic [NUM_CH-1:0] ch_inc;
  logic [CNT_W-1:0]  cnt_val [NUM_CH];

  assign in_ready   = (state == IDLE);
  assign drive_done = (state == DRIVE) && (hold_cnt == '0);
  assign ch_inc     = drive_done ? ch_onehot(cap_dest) : '0;

  // sequence select -> data -> release for one captured transfer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cap_data <= 1'b0;
      cap_dest <= '0;
      hold_cnt <= '0;
      i        <= 1'b0;
      s1       <= 1'b0;
      s0       <= 1'b0;
      drv_en   <= 1'b0;
      busy     <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            cap_data <= in_data;
            cap_dest <= in_dest;
            busy     <= 1'b1;
            state    <= SETUP;
          end
        end
        SETUP: begin
          {s1, s0} <= cap_dest;
          drv_en   <= 1'b0;
          hold_cnt <= HW'(HOLD_CYCLES - 1);
          state    <= DRIVE;
        end
        DRIVE: begin
          i      <= cap_data;
          drv_en <= 1'b1;
          if (hold_cnt == '0) begin
            state <= RELEASE;
          end else begin
            hold_cnt <= hold_cnt - HW'(1);
          end
        end
        RELEASE: begin
          drv_en <= 1'b0;
          busy   <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_cnt
    sat_counter #(
      .CNT_W(CNT_W)
    ) u_cnt (
      .clk  (clk),
      .rst_n(rst_n),
      .inc  (ch_inc[c]),
      .clr  (cnt_clr),
      .value(cnt_val[c])
    );
  end

  // status readback mux
  always_comb begin
    cnt_out = cnt_val[cnt_sel];
  end

endmodule

// File: tb/tb_demux_route_sched.sv
// Scoreboard bench for demux_route_sched.
// Expected transfers queued at accept, checked on drv_en.
module tb_demux_route_sched;

  localparam int H  = 2;
  localparam int CW = 2;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic          in_data;
  logic [1:0]    in_dest;
  logic          i;
  logic          s1;
  logic          s0;
  logic          drv_en;
  logic          busy;
  logic          cnt_clr;
  logic [1:0]    cnt_sel;
  logic [CW-1:0] cnt_out;

  demux_route_sched #(
    .HOLD_CYCLES(H),
    .CNT_W      (CW)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_data (in_data),
    .in_dest (in_dest),
    .i       (i),
    .s1      (s1),
    .s0      (s0),
    .drv_en  (drv_en),
    .busy    (busy),
    .cnt_clr (cnt_clr),
    .cnt_sel (cnt_sel),
    .cnt_out (cnt_out)
  );

  typedef struct {
    logic       data;
    logic [1:0] dest;
    int         acc;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   ncyc   = 0;
  int   mcnt[4];
  logic ylat[4];

  logic       prev_drv = 1'b0;
  int         hi_len   = 0;
  logic [1:0] cur_sel;
  logic       cur_i;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d", n, act, exp);
    end
  endtask

  task automatic fail(input string n);
    checks++;
    errors++;
    $display("FAIL %s", n);
  endtask

  function automatic void model_inc(input int ch);
    if (mcnt[ch] < (1 << CW) - 1) mcnt[ch]++;
  endfunction

  function automatic void model_clr();
    for (int c = 0; c < 4; c++) mcnt[c] = 0;
  endfunction

  // monitor: pops expected transfer at each data window
  always @(negedge clk) begin
    exp_t e;
    ncyc++;
    if (!rst_n) begin
      prev_drv = 1'b0;
      hi_len   = 0;
    end else begin
      if (drv_en && !prev_drv) begin
        if (sb.size() == 0) begin
          fail("spurious_drive");
        end else begin
          e = sb.pop_front();
          chk("mon_data", i, e.data);
          chk("mon_sel", {s1, s0}, e.dest);
          chk("mon_latency", ncyc - e.acc, 3);
        end
        cur_sel = {s1, s0};
        cur_i   = i;
        hi_len  = 1;
      end else if (drv_en) begin
        hi_len++;
        chk("mon_stable", {s1, s0, i}, {cur_sel, cur_i});
      end else if (prev_drv) begin
        chk("mon_hold_len", hi_len, H);
      end
      if (drv_en) ylat[{s1, s0}] = i;
      prev_drv = drv_en;
    end
  end

  task automatic send(input logic d, input logic [1:0] dst,
                      output int acc);
    exp_t e;
    @(negedge clk);
    #1;
    in_valid = 1'b1;
    in_data  = d;
    in_dest  = dst;
    acc      = -1;
    for (int k = 0; k < 40; k++) begin
      if (in_ready) begin
        acc    = ncyc;
        e.data = d;
        e.dest = dst;
        e.acc  = acc;
        sb.push_back(e);
        @(posedge clk);
        break;
      end
      @(negedge clk);
      #1;
    end
    if (acc < 0) fail("accept_timeout");
  endtask

  task automatic drop_valid();
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    logic ok;
    ok = 1'b0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      #1;
      if (in_ready && !busy && !drv_en && sb.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) fail("idle_timeout");
  endtask

  task automatic check_counts();
    @(negedge clk);
    #1;
    for (int c = 0; c < 4; c++) begin
      cnt_sel = 2'(c);
      #1;
      chk($sformatf("cnt_ch%0d", c), cnt_out, mcnt[c]);
    end
  endtask

  initial begin
    int a1;
    int a2;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_data  = 1'b0;
    in_dest  = 2'd0;
    cnt_clr  = 1'b0;
    cnt_sel  = 2'd0;
    model_clr();
    for (int c = 0; c < 4; c++) ylat[c] = 1'b0;

    repeat (3) @(negedge clk);
    #1;
    chk("rst_i", i, 0);
    chk("rst_sel", {s1, s0}, 0);
    chk("rst_drv", drv_en, 0);
    chk("rst_busy", busy, 0);
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    chk("rst_ready", in_ready, 1);
    check_counts();

    // single transfer timing
    send(1'b1, 2'd2, a1);
    drop_valid();
    @(negedge clk);
    chk("t1_sel_T0", {s1, s0}, 0);
    @(negedge clk);
    chk("t1_sel_T1", {s1, s0}, 2);
    chk("t1_drv_T1", drv_en, 0);
    @(negedge clk);
    chk("t1_drv_T2", {drv_en, i}, 2'b11);
    chk("t1_busy_T2", busy, 1);
    chk("t1_ready_T2", in_ready, 0);
    @(negedge clk);
    chk("t1_drv_T3", {drv_en, i}, 2'b11);
    @(negedge clk);
    chk("t1_drv_T4", drv_en, 0);
    chk("t1_ready_T4", in_ready, 1);
    model_inc(2);
    check_counts();

    // back-to-back dest 0 then dest 3
    send(1'b1, 2'd0, a1);
    send(1'b0, 2'd3, a2);
    drop_valid();
    chk("b2b_gap", a2 - a1, H + 3);
    wait_idle();
    chk("b2b_y0_kept", ylat[0], 1);
    chk("b2b_y3", ylat[3], 0);
    model_inc(0);
    model_inc(3);
    check_counts();

    // request held while busy
    send(1'b1, 2'd1, a1);
    #1;
    in_valid = 1'b1;
    in_data  = 1'b0;
    in_dest  = 2'd2;
    @(negedge clk);
    chk("busy_ready0", in_ready, 0);
    @(negedge clk);
    chk("busy_ready1", in_ready, 0);
    send(1'b0, 2'd2, a2);
    drop_valid();
    chk("busy_gap", a2 - a1, H + 3);
    wait_idle();
    model_inc(1);
    model_inc(2);
    check_counts();

    // clear, then saturate channel 1
    @(negedge clk);
    #1;
    cnt_clr = 1'b1;
    @(negedge clk);
    #1;
    cnt_clr = 1'b0;
    model_clr();
    check_counts();
    for (int k = 0; k < 5; k++) begin
      send(1'($urandom), 2'd1, a1);
      drop_valid();
      wait_idle();
      model_inc(1);
      cnt_sel = 2'd1;
      #1;
      chk($sformatf("sat_%0d", k), cnt_out, mcnt[1]);
    end

    // clear colliding with the dest 0 increment
    send(1'b1, 2'd0, a1);
    drop_valid();
    repeat (3) @(negedge clk);
    #1;
    cnt_clr = 1'b1;
    @(negedge clk);
    #1;
    cnt_sel = 2'd0;
    #1;
    chk("clr_vs_inc", cnt_out, 0);
    cnt_clr = 1'b0;
    model_clr();
    wait_idle();
    check_counts();

    // reset during the data window
    send(1'b1, 2'd3, a1);
    drop_valid();
    model_inc(3);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (drv_en) break;
    end
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_i", i, 0);
    chk("mid_rst_sel", {s1, s0}, 0);
    chk("mid_rst_drv", drv_en, 0);
    chk("mid_rst_busy", busy, 0);
    model_clr();
    for (int c = 0; c < 4; c++) begin
      cnt_sel = 2'(c);
      #1;
      chk($sformatf("mid_rst_cnt%0d", c), cnt_out, 0);
    end
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    chk("post_rst_ready", in_ready, 1);
    send(1'b0, 2'd3, a1);
    drop_valid();
    wait_idle();
    model_inc(3);
    check_counts();

    // randomized traffic
    for (int k = 0; k < 32; k++) begin
      send(1'($urandom), 2'($urandom_range(0, 3)), a1);
      model_inc(int'(in_dest));
      if ((k % 8) == 7) begin
        drop_valid();
        wait_idle();
        check_counts();
        if ($urandom_range(0, 1) == 1) begin
          @(negedge clk);
          #1;
          cnt_clr = 1'b1;
          @(negedge clk);
          #1;
          cnt_clr = 1'b0;
          model_clr();
        end
      end else if ($urandom_range(0, 2) != 0) begin
        drop_valid();
        repeat ($urandom_range(0, 6)) @(negedge clk);
      end
    end
    drop_valid();
    wait_idle();
    check_counts();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
